tft_init_sequencer: RTL and testbench

//  Walks the TFT init table (17-bit entries {RS, data[15:0]}; index 0 unused, 1..89 valid).

---
 rtl/tft_init_sequencer.sv | 117 +++++++++++
 tb/tb_tft_init_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/tft_init_sequencer.sv
// tft_init_sequencer: pulses the panel reset, then streams the init table to the SPI serializer with power-on delays.
module tft_init_sequencer #(
    parameter int unsigned CYCLES_PER_MS = 25000,
    parameter int unsigned FIRST_IDX     = 1,
    parameter int unsigned LAST_IDX      = 89,
    parameter int unsigned RST_LOW_MS    = 10,
    parameter int unsigned RST_WAIT_MS   = 50,
    parameter int unsigned D0_IDX        = 10,
    parameter int unsigned D0_MS         = 40,
    parameter int unsigned D1_IDX        = 20,
    parameter int unsigned D1_MS         = 10,
    parameter int unsigned D2_IDX        = 22,
    parameter int unsigned D2_MS         = 50,
    parameter int unsigned D3_IDX        = 86,
    parameter int unsigned D3_MS         = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [6:0]  rom_addr,
    input  logic [16:0] rom_data,
    output logic [15:0] tx_data,
    output logic        tx_rs,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tft_rst_n,
    output logic        busy,
    output logic        done
);
    typedef enum logic [2:0] {IDLE, RST_LO, RST_WAIT, FETCH, SEND, DELAY, DONE} state_t;
    localparam logic [31:0] RST_LO_CYC   = 32'(RST_LOW_MS * CYCLES_PER_MS);
    localparam logic [31:0] RST_WAIT_CYC = 32'(RST_WAIT_MS * CYCLES_PER_MS);
    localparam logic [6:0]  FIRST        = 7'(FIRST_IDX);
    localparam logic [6:0]  LAST         = 7'(LAST_IDX);
    state_t      state_q;
    logic [31:0] cnt_q;
    logic [6:0]  rom_addr_q;
    logic [15:0] tx_data_q;
    logic        tx_rs_q;
    logic        tx_valid_q;
    logic        tft_rst_n_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] dly_d;
    // Post-accept delay for the word currently on the bus; zero means go straight to the next fetch.
    always_comb begin
        dly_d = rom_addr_q == 7'(D0_IDX) ? 32'(D0_MS * CYCLES_PER_MS) :
                rom_addr_q == 7'(D1_IDX) ? 32'(D1_MS * CYCLES_PER_MS) :
                rom_addr_q == 7'(D2_IDX) ? 32'(D2_MS * CYCLES_PER_MS) :
                rom_addr_q == 7'(D3_IDX) ? 32'(D3_MS * CYCLES_PER_MS) : 32'd0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rom_addr_q  <= FIRST;
            tx_data_q   <= '0;
            tx_rs_q     <= 1'b0;
            tx_valid_q  <= 1'b0;
            tft_rst_n_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: if (start) begin
                    state_q     <= RST_LO;
                    cnt_q       <= RST_LO_CYC;
                    rom_addr_q  <= FIRST;
                    tft_rst_n_q <= 1'b0;
                    busy_q      <= 1'b1;
                    done_q      <= 1'b0;
                end
                RST_LO: begin
                    cnt_q <= cnt_q == 32'd1 ? RST_WAIT_CYC : cnt_q - 32'd1;
                    if (cnt_q == 32'd1) begin
                        state_q     <= RST_WAIT;
                        tft_rst_n_q <= 1'b1;
                    end
                end
                RST_WAIT: begin
                    cnt_q <= cnt_q - 32'd1;
                    if (cnt_q == 32'd1) state_q <= FETCH;
                end
                FETCH: begin
                    tx_data_q  <= rom_data[15:0];
                    tx_rs_q    <= rom_data[16];
                    tx_valid_q <= 1'b1;
                    state_q    <= SEND;
                end
                SEND: if (tx_ready) begin
                    tx_valid_q <= 1'b0;
                    if (rom_addr_q == LAST) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        rom_addr_q <= rom_addr_q + 7'd1;
                        cnt_q      <= dly_d;
                        state_q    <= dly_d != 32'd0 ? DELAY : FETCH;
                    end
                end
                DELAY: begin
                    cnt_q <= cnt_q - 32'd1;
                    if (cnt_q == 32'd1) state_q <= FETCH;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign rom_addr  = rom_addr_q;
    assign tx_data   = tx_data_q;
    assign tx_rs     = tx_rs_q;
    assign tx_valid  = tx_valid_q;
    assign tft_rst_n = tft_rst_n_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_tft_init_sequencer.sv
// tb_tft_init_sequencer: scoreboard bench; driver queues expected words, monitor checks each accepted word.
module tb_tft_init_sequencer;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, tx_ready = 1'b1;
    logic [6:0]  rom_addr;
    logic [16:0] rom_data;
    logic [15:0] tx_data;
    logic        tx_rs, tx_valid, tft_rst_n, busy, done;
    tft_init_sequencer #(.CYCLES_PER_MS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
        .tx_data(tx_data), .tx_rs(tx_rs), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tft_rst_n(tft_rst_n), .busy(busy), .done(done)
    );
    always #5 clk = ~clk;
    function automatic logic [16:0] tbl(input logic [6:0] a);
        logic [7:0] b;
        b = {1'b0, a};
        if (a == 7'd1) return 17'h00010;
        if (a == 7'd14) return 17'h16121;
        return {a[0], b ^ 8'h3C, b};
    endfunction
    assign rom_data = tbl(rom_addr);
    typedef struct packed {
        logic [6:0]  idx;
        logic [16:0] w;
        logic [31:0] gap;
    } exp_t;
    exp_t exp_q[$];
    int checks = 0, passes = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask
    function automatic int dly_of(input int i);
        return i == 10 ? 160 : i == 20 ? 40 : i == 22 ? 200 : i == 86 ? 200 : 0;
    endfunction
    // Handshake spacing is 2 cycles (FETCH + SEND) plus any power-on delay after the previous index.
    task automatic push_run(input bit stall14);
        for (int i = 1; i <= 89; i++) begin
            exp_t e;
            e.idx = 7'(i);
            e.w   = tbl(7'(i));
            e.gap = i == 1 ? 32'd0 : (stall14 && i == 14) ? 32'd8 : 32'(2 + dly_of(i - 1));
            exp_q.push_back(e);
        end
    endtask
    int cyc = 0, last_hs = 0, done_rises = 0;
    logic prev_stall = 1'b0, prev_done = 1'b0;
    logic [16:0] prev_w = '0;
    exp_t m;
    always @(negedge clk) begin
        cyc++;
        if (!rst && done && !prev_done) done_rises++;
        prev_done = done;
        if (prev_stall && !rst) begin
            chk("hold_valid", 32'(tx_valid), 32'd1);
            chk("hold_word", 32'({tx_rs, tx_data}), 32'(prev_w));
        end
        prev_stall = tx_valid && !tx_ready && !rst;
        prev_w = {tx_rs, tx_data};
        if (tx_valid && tx_ready && !rst) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_word: got idx %0d word 0x%0h, required none", rom_addr, {tx_rs, tx_data});
            end else begin
                m = exp_q.pop_front();
                chk("hs_idx", 32'(rom_addr), 32'(m.idx));
                chk("hs_word", 32'({tx_rs, tx_data}), 32'(m.w));
                if (m.gap != 0) chk("hs_gap", 32'(cyc - last_hs), m.gap);
            end
            last_hs = cyc;
        end
    end
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic wait_addr(input logic [6:0] a);
        int n = 0;
        while (rom_addr != a && n < 3000) begin n++; tick(1); end
        chk("reach_addr", 32'(rom_addr), 32'(a));
    endtask
    task automatic wait_done();
        int n = 0;
        while (!done && n < 5000) begin n++; tick(1); end
        chk("done_seen", 32'(done), 32'd1);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask
    task automatic run_start(input bit poke_start);
        int n = 0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        while (!tft_rst_n && n < 1000) begin n++; tick(1); end
        chk("rst_low_cycles", 32'(n), 32'd40);
        n = 0;
        while (!tx_valid && n < 1000) begin
            start = poke_start && n == 5;
            n++;
            tick(1);
        end
        start = 1'b0;
        chk("first_valid_delay", 32'(n), 32'd201);
        chk("first_word", 32'({tx_rs, tx_data}), 32'h00010);
    endtask
    initial begin
        tick(3);
        chk("rst_addr", 32'(rom_addr), 32'd1);
        chk("rst_outs", 32'({tx_valid, tx_rs, tx_data, tft_rst_n, busy, done}), 32'h00000_4);
        rst = 1'b0;
        tick(3);
        chk("idle_ready_ignored", 32'({tx_valid, tft_rst_n, busy}), 32'b010);
        push_run(1'b1);
        done_rises = 0;
        fork
            run_start(1'b1);
        join
        wait_addr(7'd14);
        tx_ready = 1'b0;
        tick(4);
        chk("stall_word", 32'({tx_valid, tx_rs, tx_data}), 32'h36121);
        tick(3);
        tx_ready = 1'b1;
        wait_addr(7'd50);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done();
        chk("last_addr", 32'(rom_addr), 32'd89);
        tick(5);
        chk("single_done", 32'(done_rises), 32'd1);
        push_run(1'b0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("rerun_done_clear", 32'({done, busy, tft_rst_n}), 32'b010);
        wait_addr(7'd21);
        tick(10);
        chk("in_delay", 32'({tx_valid, busy}), 32'b01);
        rst = 1'b1;
        tick(1);
        chk("midrun_rst_addr", 32'(rom_addr), 32'd1);
        chk("midrun_rst_outs", 32'({tx_valid, busy, done, tft_rst_n}), 32'b0001);
        rst = 1'b0;
        exp_q.delete();
        tick(2);
        push_run(1'b0);
        run_start(1'b0);
        wait_done();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end
endmodule
